// File: rtl/colisao_pkg.sv
// Screen limits and move-FSM encoding shared by the collision detector and
// the position controller.
package colisao_pkg;

  localparam int monitor_min_x = 1;
  localparam int monitor_max_x = 640;
  localparam int monitor_min_y = 1;
  localparam int monitor_max_y = 480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_MOVE   = 2'd2,
    ST_SETTLE = 2'd3
  } move_state_t;

endpackage

// File: rtl/move_objeto_if.sv
// Keyboard, collision-flag and position bundle between the controller and its
// neighbours (keyboard decoder, collision detector, VGA drawing logic).
interface move_objeto_if;
  logic       enable;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       colisao_max_x;
  logic       colisao_min_x;
  logic       colisao_max_y;
  logic       colisao_min_y;
  logic [6:0] tamanho;
  logic [9:0] xPos;
  logic [8:0] yPos;
  logic       moved;
  logic       busy;
  logic       tick_missed;

  modport master (
    output enable, key_up, key_down, key_left, key_right,
    output colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y, tamanho,
    input  xPos, yPos, moved, busy, tick_missed
  );

  modport slave (
    input  enable, key_up, key_down, key_left, key_right,
    input  colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y, tamanho,
    output xPos, yPos, moved, busy, tick_missed
  );
endinterface

// File: rtl/move_objeto_divisor_tick.sv
// Free-running movement-tick divider: one-cycle tick every TICK_DIV enabled
// cycles; the count freezes while enable is low.
module divisor_tick #(
  parameter int TICK_DIV = 833333
) (
  input  logic VGA_clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == CW'(TICK_DIV - 1)) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/move_objeto.sv
// Object position controller: on each movement tick latches the keys, checks
// the detector's blocking flags and steps (xPos, yPos) inside the monitor area.
module move_objeto
  import colisao_pkg::*;
#(
  parameter int TICK_DIV = 833333,
  parameter int STEP     = 2,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int SETTLE   = 2
) (
  input  logic         VGA_clk,
  input  logic         reset,
  move_objeto_if.slave mo
);

  logic               tick;
  move_state_t        state;
  logic [3:0]         keys_q;        // {up, down, left, right}
  logic signed [1:0]  dx, dy, dx_q, dy_q;
  logic [2:0]         settle_cnt;
  logic [9:0]         x_q;
  logic [8:0]         y_q;
  logic               busy_q, moved_q, missed_q;
  logic [10:0]        hi_x, hi_y, nx, ny;

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_div (
    .VGA_clk (VGA_clk),
    .reset   (reset),
    .enable  (mo.enable),
    .tick    (tick)
  );

  // Step one axis by dir*STEP and saturate into [lo, hi]; lo wins if hi < lo.
  function automatic logic [10:0] clamp_step(input logic [10:0]       pos,
                                             input logic signed [1:0] dir,
                                             input logic [10:0]       lo,
                                             input logic [10:0]       hi);
    logic [10:0] step_w;
    logic [10:0] cand;
    step_w = 11'(STEP);
    if (dir == 2'sd1)       cand = pos + step_w;
    else if (dir == -2'sd1) cand = (pos < lo + step_w) ? lo : pos - step_w;
    else                    cand = pos;
    if (cand > hi) cand = hi;
    if (cand < lo) cand = lo;
    return cand;
  endfunction

  // Screen y grows downward, so "up" heads toward min_y.
  always_comb begin
    dx = 2'sd0;
    dy = 2'sd0;
    if (keys_q[0] && !keys_q[1] && !mo.colisao_max_x)      dx = 2'sd1;
    else if (keys_q[1] && !keys_q[0] && !mo.colisao_min_x) dx = -2'sd1;
    if (keys_q[2] && !keys_q[3] && !mo.colisao_max_y)      dy = 2'sd1;
    else if (keys_q[3] && !keys_q[2] && !mo.colisao_min_y) dy = -2'sd1;
  end

  assign hi_x = 11'(monitor_max_x) - 11'(mo.tamanho);
  assign hi_y = 11'(monitor_max_y) - 11'(mo.tamanho);
  assign nx   = clamp_step({1'b0, x_q}, dx_q, 11'(monitor_min_x), hi_x);
  assign ny   = clamp_step({2'b0, y_q}, dy_q, 11'(monitor_min_y), hi_y);

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      moved_q    <= 1'b0;
      missed_q   <= 1'b0;
      settle_cnt <= '0;
      keys_q     <= '0;
      dx_q       <= 2'sd0;
      dy_q       <= 2'sd0;
      x_q        <= 10'(X_INIT);
      y_q        <= 9'(Y_INIT);
    end else begin
      moved_q  <= 1'b0;
      missed_q <= tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (tick) begin
            keys_q <= {mo.key_up, mo.key_down, mo.key_left, mo.key_right};
            state  <= ST_EVAL;
            busy_q <= 1'b1;
          end
        end
        ST_EVAL: begin
          dx_q <= dx;
          dy_q <= dy;
          if (dx == 2'sd0 && dy == 2'sd0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            state <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          x_q        <= nx[9:0];
          y_q        <= ny[8:0];
          moved_q    <= (nx != {1'b0, x_q}) || (ny != {2'b0, y_q});
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Hold off the next evaluation until the detector has sampled us.
          if (settle_cnt == 3'(SETTLE - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mo.xPos        = x_q;
  assign mo.yPos        = y_q;
  assign mo.moved       = moved_q;
  assign mo.busy        = busy_q;
  assign mo.tick_missed = missed_q;

endmodule

// File: tb/tb_move_objeto.sv
// Scoreboard bench for move_objeto: three instances (nominal, start at the
// right/top edge, over-long settle) exercised one at a time.
module tb_move_objeto;

  typedef struct {
    int   dut;
    logic exp_moved;
    int   x;
    int   y;
    int   missed;
    int   start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       en    [3];
  logic [3:0] keys  [3];   // {up, down, left, right}
  logic [3:0] flags [3];   // {max_x, min_x, max_y, min_y}
  logic [9:0] xo    [3];
  logic [8:0] yo    [3];
  logic       mv    [3];
  logic       by    [3];
  logic       tm    [3];

  int   x_init [3] = '{320, 619, 320};
  int   y_init [3] = '{240, 3, 240};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    move_objeto_if bus ();
    assign bus.enable = en[g];
    assign {bus.key_up, bus.key_down, bus.key_left, bus.key_right} = keys[g];
    assign {bus.colisao_max_x, bus.colisao_min_x, bus.colisao_max_y, bus.colisao_min_y} = flags[g];
    assign bus.tamanho = 7'd20;
    assign xo[g] = bus.xPos;
    assign yo[g] = bus.yPos;
    assign mv[g] = bus.moved;
    assign by[g] = bus.busy;
    assign tm[g] = bus.tick_missed;

    move_objeto #(
      .TICK_DIV (g == 2 ? 4 : 8),
      .STEP     (2),
      .X_INIT   (g == 1 ? 619 : 320),
      .Y_INIT   (g == 1 ? 3 : 240),
      .SETTLE   (g == 2 ? 7 : 2)
    ) dut (
      .VGA_clk (clk),
      .reset   (rst),
      .mo      (bus)
    );
  end

  exp_t sb [$];
  int   done_cnt [3];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic m, input int x, input int y,
                      input int ms, input int st);
    exp_t e;
    e.dut = d; e.exp_moved = m; e.x = x; e.y = y; e.missed = ms; e.start = st;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int d, input int target);
    int budget;
    budget = 500;
    while (done_cnt[d] < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk($sformatf("dut%0d_txn_count", d), done_cnt[d], target);
  endtask

  // One transaction = one busy window; expectations are popped at its start.
  task automatic monitor();
    logic bprev [3];
    logic have  [3];
    logic seen  [3];
    int   miss  [3];
    int   t0    [3];
    exp_t cur   [3];
    for (int i = 0; i < 3; i++) begin
      bprev[i] = 1'b0; have[i] = 1'b0; seen[i] = 1'b0; miss[i] = 0; t0[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (by[i] && !bprev[i]) begin
          seen[i] = 1'b0; miss[i] = 0; t0[i] = cyc; have[i] = 1'b0;
          chk($sformatf("dut%0d_txn_expected", i), int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            cur[i]  = sb.pop_front();
            have[i] = 1'b1;
            chk($sformatf("dut%0d_txn_owner", i), i, cur[i].dut);
            if (cur[i].start >= 0)
              chk($sformatf("dut%0d_txn_start_cycle", i), t0[i], cur[i].start);
          end
        end
        if (tm[i]) miss[i]++;
        if (mv[i] && have[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("dut%0d_moved_xPos", i), int'(xo[i]), cur[i].x);
          chk($sformatf("dut%0d_moved_yPos", i), int'(yo[i]), cur[i].y);
          chk($sformatf("dut%0d_moved_latency", i), cyc - t0[i], 2);
        end
        if (!by[i] && bprev[i] && have[i]) begin
          chk($sformatf("dut%0d_moved_pulse", i), int'(seen[i]), int'(cur[i].exp_moved));
          if (!cur[i].exp_moved) begin
            chk($sformatf("dut%0d_hold_xPos", i), int'(xo[i]), cur[i].x);
            chk($sformatf("dut%0d_hold_yPos", i), int'(yo[i]), cur[i].y);
          end
          chk($sformatf("dut%0d_tick_missed_count", i), miss[i], cur[i].missed);
          have[i] = 1'b0;
          done_cnt[i]++;
        end
        bprev[i] = by[i];
      end
    end
  endtask

  initial begin
    int budget;
    int c0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; keys[i] = 4'b0000; flags[i] = 4'b0000; done_cnt[i] = 0;
    end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d_reset_xPos", i), int'(xo[i]), x_init[i]);
      chk($sformatf("dut%0d_reset_yPos", i), int'(yo[i]), y_init[i]);
      chk($sformatf("dut%0d_reset_busy", i), int'(by[i]), 0);
      chk($sformatf("dut%0d_reset_moved", i), int'(mv[i]), 0);
      chk($sformatf("dut%0d_reset_tick_missed", i), int'(tm[i]), 0);
    end
    fork
      monitor();
    join_none
    rst = 1'b0;

    // dut0: first move to 322, then reset lands in SETTLE
    keys[0] = 4'b0001; en[0] = 1'b1;
    push(0, 1'b1, 322, 240, 0, -1);
    budget = 200;
    while (!mv[0] && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("dut0_first_move_seen", int'(mv[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_xPos", int'(xo[0]), 320);
    chk("async_reset_yPos", int'(yo[0]), 240);
    chk("async_reset_busy", int'(by[0]), 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // dut0: three right ticks, blocked left, diagonal, opposite keys
    push(0, 1'b1, 322, 240, 0, -1);
    push(0, 1'b1, 324, 240, 0, -1);
    push(0, 1'b1, 326, 240, 0, -1);
    wait_done(0, 4);
    keys[0] = 4'b0010; flags[0] = 4'b0100;
    push(0, 1'b0, 326, 240, 0, -1);
    wait_done(0, 5);
    keys[0] = 4'b1010;
    push(0, 1'b1, 326, 238, 0, -1);
    wait_done(0, 6);
    keys[0] = 4'b0011; flags[0] = 4'b0000;
    push(0, 1'b0, 326, 238, 0, -1);
    wait_done(0, 7);
    en[0] = 1'b0; keys[0] = 4'b0000;

    // dut1: right-edge clamp, top-edge clamp, diagonal away from the corner
    en[1] = 1'b1; keys[1] = 4'b0001;
    push(1, 1'b1, 620, 3, 0, -1);
    push(1, 1'b0, 620, 3, 0, -1);
    wait_done(1, 2);
    keys[1] = 4'b1000;
    push(1, 1'b1, 620, 1, 0, -1);
    push(1, 1'b0, 620, 1, 0, -1);
    wait_done(1, 4);
    keys[1] = 4'b0110;
    push(1, 1'b1, 618, 3, 0, -1);
    wait_done(1, 5);
    en[1] = 1'b0; keys[1] = 4'b0000;

    // dut2: settle longer than the tick period drops two ticks per move
    en[2] = 1'b1; keys[2] = 4'b0001;
    push(2, 1'b1, 322, 240, 2, -1);
    push(2, 1'b1, 324, 240, 2, -1);
    wait_done(2, 2);
    keys[2] = 4'b0000;
    push(2, 1'b0, 324, 240, 0, -1);
    wait_done(2, 3);
    // counter parked at 2 of 4; a frozen divider ticks 2 edges after re-enable
    en[2] = 1'b0; keys[2] = 4'b0001;
    repeat (101) begin
      @(negedge clk); #1;
    end
    chk("dut2_disabled_xPos", int'(xo[2]), 324);
    chk("dut2_disabled_busy", int'(by[2]), 0);
    c0 = cyc;
    push(2, 1'b1, 326, 240, 2, c0 + 3);
    en[2] = 1'b1;
    wait_done(2, 4);
    en[2] = 1'b0; keys[2] = 4'b0000;

    repeat (4) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_objeto.md
Name: move_objeto

Overview:
- Position controller on the consuming end of the collision interface.
- Takes keyboard direction levels and the four registered collision flags from the collision detector (colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y).
- Advances the object's top-left position (xPos, yPos) once per movement tick, clamped to the monitor area.
- Its xPos/yPos outputs feed back into the collision detector and into the VGA drawing logic.

Parameters:
- TICK_DIV, 833333: VGA_clk cycles per movement tick (60 Hz at 50 MHz). Minimum 8.
- STEP, 2: pixels moved per tick per axis, 1..15.
- X_INIT, 320: xPos after reset.
- Y_INIT, 240: yPos after reset.
- SETTLE, 2: cycles waited after a move for the detector flags to refresh, 2..7.

Ports:
- VGA_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  when low, tick counter holds and no moves start.
- key_up, key_down, key_left, key_right  in  1 each  direction levels, 1 = pressed.
- colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y  in  1 each  blocking flags from the detector.
- tamanho  in  7  object side length in pixels.
- xPos  out  10  object x, range [1, 640-tamanho].
- yPos  out  9  object y, range [1, 480-tamanho].
- moved  out  1  one-cycle pulse when position changed.
- busy  out  1  high in any state other than IDLE.
- tick_missed  out  1  one-cycle pulse when a tick arrives while not IDLE.

Behaviour:
- Interface (decided): one clock, VGA_clk; reset is asynchronous and active-high, named reset.
- Reset values, applied immediately on assert, including mid-move:
  - xPos = X_INIT, yPos = Y_INIT.
  - moved = 0, busy = 0, tick_missed = 0.
  - State = IDLE, tick counter = 0, settle counter = 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable = 1.
  - On wrap it emits an internal tick for 1 cycle.
  - enable = 0 freezes the count and suppresses ticks.
- FSM, all transitions on posedge VGA_clk:
  - IDLE: on tick, latch the four keys and go to EVAL.
  - EVAL (1 cycle), per axis:
    - dx = +1 if key_right & ~key_left & ~colisao_max_x.
    - dx = -1 if key_left & ~key_right & ~colisao_min_x.
    - Otherwise dx = 0. Both opposite keys pressed → dx = 0. dy is computed the same way from up/down and the y flags.
    - Flags are sampled in this cycle.
    - If dx = dy = 0, go to IDLE with no pulse; otherwise go to MOVE.
  - MOVE (1 cycle):
    - Compute in 11-bit unsigned arithmetic: nx = xPos ± STEP, clamped to [1, 640-tamanho]; ny likewise, clamped to [1, 480-tamanho].
    - A subtraction below 1 clamps to 1.
    - Register nx/ny; pulse moved only if nx≠xPos or ny≠yPos.
    - Go to SETTLE.
  - SETTLE: wait SETTLE cycles, so the detector, which registers on the falling edge, reflects the new position. Then go to IDLE.
- Latency: move occurs 2 cycles after the tick (IDLE→EVAL→MOVE); xPos/yPos update on the MOVE edge.
- Key changes after the latch have no effect until the next tick.
- Diagonal motion is allowed; the axes are independent, and a collision on one axis does not block the other.
- A tick in EVAL, MOVE or SETTLE is dropped and pulses tick_missed. This is not possible when TICK_DIV ≥ SETTLE+3.
- If tamanho is large enough that the clamp upper bound is below 1, clamp to 1.

Decomposition:
- Shared package (colisao_pkg):
  - monitor_min_x = 1, monitor_max_x = 640, monitor_min_y = 1, monitor_max_y = 480.
  - Move FSM state encoding IDLE/EVAL/MOVE/SETTLE.
  - The collision detector is switched to the same limit constants.
- One sub-module, divisor_tick: parameter TICK_DIV; ports VGA_clk, reset, enable, tick.

Test Plan (TICK_DIV = 8, STEP = 2, SETTLE = 2, tamanho = 20, flags driven by the bench):
- Reset is asserted mid-SETTLE after a move to 322 → xPos = 320, yPos = 240, and busy = 0 asynchronously, before the next edge.
- key_right held for 3 ticks → xPos goes 322, 324, 326. Each moved pulse comes exactly 2 cycles after its tick. yPos stays 240.
- Start at xPos = 619 with key_right → xPos = 620 (clamped to 640-20). The next tick produces no moved pulse.
- key_left held with colisao_min_x = 1 → xPos unchanged and no moved pulse. Then with key_up also held, yPos goes 240→238 and moved pulses.
- key_left and key_right both held → no x change. yPos = 1 with key_up → stays 1 and no moved pulse.
- TICK_DIV = 4, SETTLE = 7 (violating the minimum) → tick_missed pulses once per dropped tick. enable = 0 → counter frozen and no moves for 100 cycles.
